// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/flush/halt controller:
// state encoding, drain length, PC redirect codes and stage bit positions.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // Cycles the back end needs to retire everything ahead of the halting syscall.
    localparam int DRAIN_CYCLES = 3;
    localparam int DRAIN_CNT_W  = $clog2(DRAIN_CYCLES + 1);

    // PC source select.
    localparam logic [1:0] REDIR_SEQ     = 2'b00;
    localparam logic [1:0] REDIR_BRANCH  = 2'b01;
    localparam logic [1:0] REDIR_SYSCALL = 2'b10;

    // Pipeline register positions within en_ps / clear_ps.
    localparam int STG_IF_ID  = 0;
    localparam int STG_ID_EX  = 1;
    localparam int STG_EX_MEM = 2;
    localparam int STG_MEM_WB = 3;

    function automatic logic [3:0] stage_bit(input int idx);
        return 4'b0001 << idx;
    endfunction

    localparam logic [3:0] EN_NONE   = 4'b0000;
    localparam logic [3:0] EN_ALL    = stage_bit(STG_IF_ID) | stage_bit(STG_ID_EX) |
                                       stage_bit(STG_EX_MEM) | stage_bit(STG_MEM_WB);
    // Load-use stall: freeze IF/ID (and PC), let EX onward advance.
    localparam logic [3:0] EN_STALL  = EN_ALL & ~stage_bit(STG_IF_ID);
    // Squash the two younger stages fetched down the wrong path.
    localparam logic [3:0] CLR_FRONT = stage_bit(STG_IF_ID) | stage_bit(STG_ID_EX);
    // Insert a bubble into ID/EX only.
    localparam logic [3:0] CLR_IDEX  = stage_bit(STG_ID_EX);

    typedef struct packed {
        logic       pc_en;
        logic [1:0] redirect;
        logic [3:0] en_ps;
        logic [3:0] clear_ps;
    } ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up until every bit is set, then hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline controller: load-use stalls, mispredict flushes,
// memory back-pressure and a syscall-driven drain-then-halt sequence.
//
// state    | meaning
// ST_RUN   | normal issue; stalls and flushes resolved by priority
// ST_DRAIN | front end squashed, back end retiring for DRAIN_CYCLES
// ST_HALT  | pipeline frozen until resume
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld_use_hazard,
    input  logic        mispredict,
    input  logic        mem_busy,
    input  logic        syscall_halt,
    input  logic        resume,
    output logic        pc_en,
    output logic [1:0]  redirect,
    output logic [3:0]  en_ps,
    output logic [3:0]  clear_ps,
    output logic        halted,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    state_t                 state;
    logic [DRAIN_CNT_W-1:0] drain_cnt;
    ctrl_t                  ctrl;
    logic                   stall_inc;
    logic                   flush_inc;

    // Decode the current state and hazard inputs into same-cycle pipeline controls.
    always_comb begin
        ctrl      = '{pc_en: 1'b0, redirect: REDIR_SEQ, en_ps: EN_NONE, clear_ps: EN_NONE};
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        if (rst_n) begin
            unique case (state)
                ST_RUN: begin
                    if (mem_busy) begin
                        stall_inc = 1'b1;
                    end else if (mispredict) begin
                        ctrl      = '{pc_en: 1'b1, redirect: REDIR_BRANCH, en_ps: EN_ALL, clear_ps: CLR_FRONT};
                        flush_inc = 1'b1;
                    end else if (syscall_halt) begin
                        ctrl = '{pc_en: 1'b1, redirect: REDIR_SYSCALL, en_ps: EN_ALL, clear_ps: CLR_FRONT};
                    end else if (ld_use_hazard) begin
                        ctrl      = '{pc_en: 1'b0, redirect: REDIR_SEQ, en_ps: EN_STALL, clear_ps: CLR_IDEX};
                        stall_inc = 1'b1;
                    end else begin
                        ctrl = '{pc_en: 1'b1, redirect: REDIR_SEQ, en_ps: EN_ALL, clear_ps: EN_NONE};
                    end
                end
                ST_DRAIN: begin
                    // Younger instructions behind the syscall are discarded; only
                    // memory back-pressure can hold the drain.
                    if (mem_busy) begin
                        stall_inc = 1'b1;
                    end else begin
                        ctrl = '{pc_en: 1'b0, redirect: REDIR_SEQ, en_ps: EN_ALL, clear_ps: CLR_FRONT};
                    end
                end
                ST_HALT: begin
                    ctrl = '{pc_en: 1'b0, redirect: REDIR_SEQ, en_ps: EN_NONE, clear_ps: EN_NONE};
                end
                default: begin
                    ctrl = '{pc_en: 1'b0, redirect: REDIR_SEQ, en_ps: EN_NONE, clear_ps: EN_NONE};
                end
            endcase
        end
    end

    assign pc_en    = ctrl.pc_en;
    assign redirect = ctrl.redirect;
    assign en_ps    = ctrl.en_ps;
    assign clear_ps = ctrl.clear_ps;

    // State sequencing, drain down-counter and registered halted flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
            halted    <= 1'b0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (!mem_busy && !mispredict && syscall_halt) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DRAIN_CNT_W'(DRAIN_CYCLES);
                    end
                end
                ST_DRAIN: begin
                    if (!mem_busy) begin
                        if (drain_cnt == DRAIN_CNT_W'(1)) begin
                            state     <= ST_HALT;
                            drain_cnt <= '0;
                            halted    <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt - DRAIN_CNT_W'(1);
                        end
                    end
                end
                ST_HALT: begin
                    // The PC already holds the syscall pc+4 loaded on entry to drain.
                    if (resume) begin
                        state  <= ST_RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_RUN;
                    drain_cnt <= '0;
                    halted    <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.W(32)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(32)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: RUN-priority vector table, hand-written
// drain/halt/reset/saturation sequences and a randomized run against a
// behavioural model.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ld_use_hazard;
    logic        mispredict;
    logic        mem_busy;
    logic        syscall_halt;
    logic        resume;
    logic        pc_en;
    logic [1:0]  redirect;
    logic [3:0]  en_ps;
    logic [3:0]  clear_ps;
    logic        halted;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    int vectors    = 0;
    int miscompares = 0;

    pipe_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ld_use_hazard (ld_use_hazard),
        .mispredict    (mispredict),
        .mem_busy      (mem_busy),
        .syscall_halt  (syscall_halt),
        .resume        (resume),
        .pc_en         (pc_en),
        .redirect      (redirect),
        .en_ps         (en_ps),
        .clear_ps      (clear_ps),
        .halted        (halted),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive inputs just after the falling edge and let combinational outputs settle.
    task automatic set_in(input bit mb, input bit mp, input bit sc, input bit lu, input bit rs);
        @(negedge clk);
        mem_busy      = mb;
        mispredict    = mp;
        syscall_halt  = sc;
        ld_use_hazard = lu;
        resume        = rs;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_busy = 0; mispredict = 0; syscall_halt = 0; ld_use_hazard = 0; resume = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- behavioural reference model ----------------
    // mode: 0 = running, 1 = draining, 2 = halted
    int     m_mode;
    int     m_left;
    longint m_stall;
    longint m_flush;

    function automatic longint sat_inc(input longint v);
        return (v < 64'hFFFF_FFFF) ? v + 1 : v;
    endfunction

    // Expected {pc_en, redirect, en_ps, clear_ps} from the priority rules.
    function automatic logic [10:0] model_out(input bit mb, input bit mp, input bit sc, input bit lu);
        if (m_mode == 2) return {1'b0, 2'd0, 4'b0000, 4'b0000};
        if (mb)          return {1'b0, 2'd0, 4'b0000, 4'b0000};
        if (m_mode == 1) return {1'b0, 2'd0, 4'b1111, 4'b0011};
        if (mp)          return {1'b1, 2'd1, 4'b1111, 4'b0011};
        if (sc)          return {1'b1, 2'd2, 4'b1111, 4'b0011};
        if (lu)          return {1'b0, 2'd0, 4'b1110, 4'b0010};
        return {1'b1, 2'd0, 4'b1111, 4'b0000};
    endfunction

    task automatic model_step(input bit mb, input bit mp, input bit sc, input bit lu, input bit rs);
        if (m_mode == 0) begin
            if (mb)      m_stall = sat_inc(m_stall);
            else if (mp) m_flush = sat_inc(m_flush);
            else if (sc) begin m_mode = 1; m_left = 3; end
            else if (lu) m_stall = sat_inc(m_stall);
        end else if (m_mode == 1) begin
            if (mb) m_stall = sat_inc(m_stall);
            else begin
                m_left = m_left - 1;
                if (m_left == 0) m_mode = 2;
            end
        end else begin
            if (rs) m_mode = 0;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit         mb, mp, sc, lu;
        logic       pc_en;
        logic [1:0] redir;
        logic [3:0] en;
        logic [3:0] clr;
        int         dstall;
        int         dflush;
    } vec_t;

    vec_t tbl[8];

    initial begin
        rst_n = 1'b0;
        mem_busy = 0; mispredict = 0; syscall_halt = 0; ld_use_hazard = 0; resume = 0;

        tbl[0] = '{0,0,0,0, 1'b1, 2'b00, 4'b1111, 4'b0000, 0, 0};
        tbl[1] = '{0,0,0,1, 1'b0, 2'b00, 4'b1110, 4'b0010, 1, 0};
        tbl[2] = '{0,1,0,0, 1'b1, 2'b01, 4'b1111, 4'b0011, 0, 1};
        tbl[3] = '{0,1,0,1, 1'b1, 2'b01, 4'b1111, 4'b0011, 0, 1};
        tbl[4] = '{0,0,1,0, 1'b1, 2'b10, 4'b1111, 4'b0011, 0, 0};
        tbl[5] = '{0,0,1,1, 1'b1, 2'b10, 4'b1111, 4'b0011, 0, 0};
        tbl[6] = '{1,1,1,1, 1'b0, 2'b00, 4'b0000, 4'b0000, 1, 0};
        tbl[7] = '{0,1,1,0, 1'b1, 2'b01, 4'b1111, 4'b0011, 0, 1};

        // Reset state while rst_n is held low.
        @(posedge clk);
        #1;
        chk("rst_pc_en", 32'(pc_en), 32'd0);
        chk("rst_en_ps", 32'(en_ps), 32'd0);
        chk("rst_clear_ps", 32'(clear_ps), 32'd0);
        chk("rst_redirect", 32'(redirect), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        chk("rst_flush_cnt", flush_cnt, 32'd0);

        // RUN priority table, one fresh reset per row.
        for (int i = 0; i < 8; i++) begin
            do_reset();
            set_in(tbl[i].mb, tbl[i].mp, tbl[i].sc, tbl[i].lu, 1'b0);
            chk($sformatf("tbl%0d_pc_en", i), 32'(pc_en), 32'(tbl[i].pc_en));
            chk($sformatf("tbl%0d_redirect", i), 32'(redirect), 32'(tbl[i].redir));
            chk($sformatf("tbl%0d_en_ps", i), 32'(en_ps), 32'(tbl[i].en));
            chk($sformatf("tbl%0d_clear_ps", i), 32'(clear_ps), 32'(tbl[i].clr));
            set_in(0, 0, 0, 0, 0);
            chk($sformatf("tbl%0d_stall_cnt", i), stall_cnt, 32'(tbl[i].dstall));
            chk($sformatf("tbl%0d_flush_cnt", i), flush_cnt, 32'(tbl[i].dflush));
        end

        // Syscall halt: redirect, 3 drain cycles, halted on cycle 5, resume.
        do_reset();
        set_in(0, 0, 1, 0, 0);
        chk("sys_redirect", 32'(redirect), 32'd2);
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1, 0, 1, 0);
            chk($sformatf("drain%0d_pc_en", i), 32'(pc_en), 32'd0);
            chk($sformatf("drain%0d_en_ps", i), 32'(en_ps), 32'hF);
            chk($sformatf("drain%0d_clear_ps", i), 32'(clear_ps), 32'h3);
            chk($sformatf("drain%0d_halted", i), 32'(halted), 32'd0);
        end
        set_in(0, 0, 0, 0, 0);
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_en_ps", 32'(en_ps), 32'd0);
        chk("halt_flush_cnt", flush_cnt, 32'd0);
        set_in(1, 0, 0, 0, 1);
        chk("resume_cycle_halted", 32'(halted), 32'd1);
        set_in(0, 0, 0, 0, 0);
        chk("after_resume_halted", 32'(halted), 32'd0);
        chk("after_resume_en_ps", 32'(en_ps), 32'hF);
        chk("after_resume_pc_en", 32'(pc_en), 32'd1);
        chk("after_resume_redirect", 32'(redirect), 32'd0);
        chk("after_resume_stall_cnt", stall_cnt, 32'd0);

        // mem_busy for 2 cycles mid-drain delays halt by exactly 2 cycles.
        do_reset();
        set_in(0, 0, 1, 0, 0);
        set_in(0, 0, 0, 0, 0);
        set_in(1, 0, 0, 0, 0);
        chk("drain_busy0_en_ps", 32'(en_ps), 32'd0);
        set_in(1, 0, 0, 0, 0);
        chk("drain_busy1_en_ps", 32'(en_ps), 32'd0);
        set_in(0, 0, 0, 0, 0);
        chk("drain_busy_c5_halted", 32'(halted), 32'd0);
        set_in(0, 0, 0, 0, 0);
        chk("drain_busy_c6_halted", 32'(halted), 32'd0);
        set_in(0, 0, 0, 0, 0);
        chk("drain_busy_c7_halted", 32'(halted), 32'd1);
        chk("drain_busy_stall_cnt", stall_cnt, 32'd2);

        // Stall counter saturation.
        do_reset();
        @(negedge clk);
        force dut.u_stall_cnt.count = 32'hFFFF_FFFE;
        #1;
        release dut.u_stall_cnt.count;
        #1;
        chk("sat_preload", stall_cnt, 32'hFFFF_FFFE);
        set_in(0, 0, 0, 1, 0);
        set_in(0, 0, 0, 1, 0);
        chk("sat_one", stall_cnt, 32'hFFFF_FFFF);
        set_in(0, 0, 0, 1, 0);
        set_in(0, 0, 0, 0, 0);
        chk("sat_hold", stall_cnt, 32'hFFFF_FFFF);

        // Reset while halted.
        do_reset();
        set_in(0, 0, 1, 0, 0);
        repeat (3) set_in(0, 0, 0, 0, 0);
        set_in(0, 0, 0, 0, 0);
        chk("pre_rst_halted", 32'(halted), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_in_halt_halted", 32'(halted), 32'd0);
        chk("rst_in_halt_en_ps", 32'(en_ps), 32'd0);
        chk("rst_in_halt_pc_en", 32'(pc_en), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_in_halt_en_ps_held", 32'(en_ps), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 0);
        chk("post_rst_en_ps", 32'(en_ps), 32'hF);
        chk("post_rst_pc_en", 32'(pc_en), 32'd1);
        chk("post_rst_halted", 32'(halted), 32'd0);

        // Randomized run against the behavioural model.
        do_reset();
        m_mode = 0; m_left = 0; m_stall = 0; m_flush = 0;
        for (int n = 0; n < 3000; n++) begin
            bit mb, mp, sc, lu, rs;
            logic [10:0] exp_o;
            mb = ($urandom_range(0, 3) == 0);
            mp = ($urandom_range(0, 4) == 0);
            sc = ($urandom_range(0, 9) == 0);
            lu = ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 2) == 0);
            set_in(mb, mp, sc, lu, rs);
            exp_o = model_out(mb, mp, sc, lu);
            chk("rnd_ctrl", {21'd0, pc_en, redirect, en_ps, clear_ps}, {21'd0, exp_o});
            chk("rnd_halted", 32'(halted), 32'(m_mode == 2));
            chk("rnd_stall_cnt", stall_cnt, m_stall[31:0]);
            chk("rnd_flush_cnt", flush_cnt, m_flush[31:0]);
            model_step(mb, mp, sc, lu, rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL provide: clk  input  1  rising-edge clock.
REQ-002 SHALL provide: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL provide: ld_use_hazard  input  1  ID instruction needs the result of the load in EX.
REQ-004 SHALL provide: mispredict  input  1  EX-resolved next PC differs from the guessed PC.
REQ-005 SHALL provide: mem_busy  input  1  data-memory access in MEM not yet complete.
REQ-006 SHALL provide: syscall_halt  input  1  the syscall in EX requests halt.
REQ-007 SHALL provide: resume  input  1  external restart request.
REQ-008 SHALL provide: pc_en  output  1  PC register load enable.
REQ-009 SHALL provide: redirect  output  2  PC source: 00 sequential/guess, 01 branch target, 10 syscall pc+4.
REQ-010 SHALL provide: en_ps  output  4  per-stage register enable; bit0 IF/ID, bit1 ID/EX, bit2 EX/MEM, bit3 MEM/WB.
REQ-011 SHALL provide: clear_ps  output  4  per-stage synchronous clear, same bit order.
REQ-012 SHALL provide: halted  output  1  registered; high in HALT.
REQ-013 SHALL provide: stall_cnt  output  32  stall-cycle count; flush_cnt  output  32  mispredict-flush count.

Function
REQ-014 SHALL implement states RUN, DRAIN, HALT; pc_en/redirect/en_ps/clear_ps combinational from state and inputs, effective in the same cycle.
REQ-015 SHALL apply RUN priority mem_busy > mispredict > syscall_halt > ld_use_hazard > none.
REQ-016 None: pc_en=1, redirect=00, en_ps=1111, clear_ps=0000.
REQ-017 mem_busy (any state except HALT): pc_en=0, en_ps=0000, clear_ps=0000; DRAIN counter holds.
REQ-018 mispredict: pc_en=1, redirect=01, en_ps=1111, clear_ps=0011; flush_cnt +1.
REQ-019 ld_use_hazard: pc_en=0, en_ps=1110, clear_ps=0010 (bubble into ID/EX).
REQ-020 syscall_halt in RUN: pc_en=1, redirect=10, en_ps=1111, clear_ps=0011; next state DRAIN, drain counter loaded with DRAIN_CYCLES=3.
REQ-021 DRAIN: pc_en=0, en_ps=1111, clear_ps=0011; counter decrements per non-busy cycle; at 1 -> HALT next cycle; mispredict/syscall_halt/ld_use ignored.
REQ-022 HALT: pc_en=0, en_ps=0000, clear_ps=0000, halted=1; resume -> RUN next cycle, first RUN cycle fetches from the PC loaded in REQ-020.
REQ-023 resume SHALL be ignored outside HALT; in HALT resume wins over simultaneous mem_busy.
REQ-024 stall_cnt SHALL increment once per cycle in which REQ-017 or REQ-019 applies; both counters saturate at 32'hFFFF_FFFF.

Reset
REQ-025 rst_n low SHALL force, asynchronously, state=RUN, drain counter=0, halted=0, stall_cnt=0, flush_cnt=0, and pc_en=0, en_ps=0000, clear_ps=0000, redirect=00 while asserted.
REQ-026 Reset mid-DRAIN or in HALT SHALL return to RUN with no pending halt.

Structure
REQ-027 State encoding, DRAIN_CYCLES, redirect codes and stage bit indices SHALL live in the shared core header.
REQ-028 A sub-module sat_counter (32-bit, inc, saturating, async reset) SHALL be instantiated twice.

Verification
REQ-029 ld_use_hazard=1 one cycle in RUN -> pc_en=0, en_ps=1110, clear_ps=0010; stall_cnt 0->1.
REQ-030 mispredict=1 with ld_use_hazard=1 -> redirect=01, clear_ps=0011, pc_en=1; flush_cnt +1, stall_cnt unchanged.
REQ-031 syscall_halt=1 -> redirect=10 that cycle; 3 DRAIN cycles with pc_en=0; halted=1 on 5th cycle; resume=1 -> RUN, en_ps=1111.
REQ-032 mem_busy=1 for 2 cycles during DRAIN -> en_ps=0000, halted delayed by exactly 2 cycles; stall_cnt +2.
REQ-033 stall_cnt forced to 32'hFFFF_FFFE, 3 stall cycles -> holds 32'hFFFF_FFFF.
REQ-034 rst_n low in HALT -> halted=0 immediately, en_ps=0000 while low, RUN outputs after release.
